pipeline_hazard_ctrl: RTL

Per-register scoreboard and stall sequencer for the 5-stage IF/ID/EX/M/WB pipeline. It tracks pending destination-register writes with per-register countdown latencies and detects read-after-write hazards in ID. It arbitrates between D-cache freeze, branch flush, data hazards and I-cache misses, and drives the four pipeline-register write enables, the PC stall and bubble/flush controls.

---
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of ID-stage operand info, stall-cause inputs and pipeline control outputs
// exchanged between the hazard controller (slave) and the pipeline datapath (master).
interface pipeline_hazard_ctrl_if #(
    parameter int NREGS = 32,
    parameter int IDX_W = 5,
    parameter int LAT_W = 3
) ();
    logic             id_valid;
    logic [IDX_W-1:0] id_rs1;
    logic [IDX_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [IDX_W-1:0] id_rd;
    logic             id_rd_we;
    logic [LAT_W-1:0] id_lat;
    logic             flush;
    logic             icache_miss;
    logic             dcache_miss;
    logic             perf_clr;

    logic             write_enable_IF_ID;
    logic             write_enable_ID_EX;
    logic             write_enable_EX_M;
    logic             write_enable_M_WB;
    logic             stall_pc;
    logic             bubble_ID_EX;
    logic             flush_IF_ID;
    logic [NREGS-1:0] sb_busy;
    logic [1:0]       stall_reason;
    logic [31:0]      perf_hazard_cycles;
    logic [31:0]      perf_freeze_cycles;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_we, id_lat, flush, icache_miss, dcache_miss, perf_clr,
        output write_enable_IF_ID, write_enable_ID_EX, write_enable_EX_M, write_enable_M_WB,
        output stall_pc, bubble_ID_EX, flush_IF_ID, sb_busy, stall_reason,
        output perf_hazard_cycles, perf_freeze_cycles
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_we, id_lat, flush, icache_miss, dcache_miss, perf_clr,
        input  write_enable_IF_ID, write_enable_ID_EX, write_enable_EX_M, write_enable_M_WB,
        input  stall_pc, bubble_ID_EX, flush_IF_ID, sb_busy, stall_reason,
        input  perf_hazard_cycles, perf_freeze_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Register scoreboard and stall sequencer for a 5-stage pipeline.
// Define HAZ_PERF_EN to build the hazard/freeze cycle statistics counters.
module pipeline_hazard_ctrl #(
    parameter int NREGS = 32,
    parameter int IDX_W = 5,
    parameter int LAT_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hc
);
    localparam logic [1:0] RSN_RUN     = 2'd0;
    localparam logic [1:0] RSN_HAZARD  = 2'd1;
    localparam logic [1:0] RSN_IMISS   = 2'd2;
    localparam logic [1:0] RSN_DFREEZE = 2'd3;

    logic [LAT_W-1:0] sb_q [NREGS];
    logic [LAT_W-1:0] sb_d [NREGS];
    logic [1:0]       stall_reason_q;
    logic [1:0]       stall_reason_d;

    logic             rs1_busy_s;
    logic             rs2_busy_s;
    logic             hazard_s;
    logic             issue_s;
    logic [LAT_W-1:0] lat_load_s;
    logic [NREGS-1:0] busy_s;

    logic             we_if_id_s;
    logic             we_id_ex_s;
    logic             we_ex_m_s;
    logic             we_m_wb_s;
    logic             stall_pc_s;
    logic             bubble_id_ex_s;
    logic             flush_if_id_s;

    // RAW hazard detection against the scoreboard for the instruction in ID
    always_comb begin
        rs1_busy_s = hc.id_rs1_used && (hc.id_rs1 != {IDX_W{1'b0}}) &&
                     (sb_q[hc.id_rs1] != {LAT_W{1'b0}});
        rs2_busy_s = hc.id_rs2_used && (hc.id_rs2 != {IDX_W{1'b0}}) &&
                     (sb_q[hc.id_rs2] != {LAT_W{1'b0}});
        hazard_s   = hc.id_valid && (rs1_busy_s || rs2_busy_s);
        issue_s    = hc.id_valid && !hc.dcache_miss && !hc.flush && !hazard_s;
        // A latency of 0 behaves like 1, i.e. the result is usable the next cycle.
        if (hc.id_lat == {LAT_W{1'b0}}) begin
            lat_load_s = {LAT_W{1'b0}};
        end else begin
            lat_load_s = hc.id_lat - {{(LAT_W-1){1'b0}}, 1'b1};
        end
    end

    // Scoreboard next state: load on issue, otherwise count down; frozen on D-cache miss
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            sb_d[r] = sb_q[r];
            if (r == 0) begin
                sb_d[r] = {LAT_W{1'b0}};
            end else if (hc.dcache_miss) begin
                sb_d[r] = sb_q[r];
            end else if (issue_s && hc.id_rd_we && (hc.id_rd == IDX_W'(r))) begin
                sb_d[r] = lat_load_s;
            end else if (sb_q[r] != {LAT_W{1'b0}}) begin
                sb_d[r] = sb_q[r] - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
                sb_d[r] = sb_q[r];
            end
        end
    end

    // Scoreboard counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= {LAT_W{1'b0}};
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // Busy vector view of the scoreboard
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_s[r] = (sb_q[r] != {LAT_W{1'b0}});
        end
    end

    // Stall arbitration: freeze > flush > hazard > I-cache miss > run
    always_comb begin
        we_if_id_s     = 1'b1;
        we_id_ex_s     = 1'b1;
        we_ex_m_s      = 1'b1;
        we_m_wb_s      = 1'b1;
        stall_pc_s     = 1'b0;
        bubble_id_ex_s = 1'b0;
        flush_if_id_s  = 1'b0;
        stall_reason_d = RSN_RUN;
        if (hc.dcache_miss) begin
            we_if_id_s     = 1'b0;
            we_id_ex_s     = 1'b0;
            we_ex_m_s      = 1'b0;
            we_m_wb_s      = 1'b0;
            stall_pc_s     = 1'b1;
            stall_reason_d = RSN_DFREEZE;
        end else if (hc.flush) begin
            bubble_id_ex_s = 1'b1;
            flush_if_id_s  = 1'b1;
            stall_reason_d = RSN_RUN;
        end else if (hazard_s) begin
            // Hold IF/ID and the PC, let older stages drain behind a bubble.
            we_if_id_s     = 1'b0;
            stall_pc_s     = 1'b1;
            bubble_id_ex_s = 1'b1;
            stall_reason_d = RSN_HAZARD;
        end else if (hc.icache_miss) begin
            stall_pc_s     = 1'b1;
            flush_if_id_s  = 1'b1;
            stall_reason_d = RSN_IMISS;
        end else begin
            stall_reason_d = RSN_RUN;
        end
    end

    // Stall cause register, updated every cycle including during freeze
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_reason_q <= RSN_RUN;
        end else begin
            stall_reason_q <= stall_reason_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] perf_haz_q;
    logic [31:0] perf_haz_d;
    logic [31:0] perf_frz_q;
    logic [31:0] perf_frz_d;

    // Saturating statistics counters; clear wins over increment
    always_comb begin
        perf_haz_d = perf_haz_q;
        perf_frz_d = perf_frz_q;
        if (hc.perf_clr) begin
            perf_haz_d = 32'd0;
            perf_frz_d = 32'd0;
        end else begin
            if ((stall_reason_d == RSN_HAZARD) && (perf_haz_q != 32'hFFFF_FFFF)) begin
                perf_haz_d = perf_haz_q + 32'd1;
            end else begin
                perf_haz_d = perf_haz_q;
            end
            if (hc.dcache_miss && (perf_frz_q != 32'hFFFF_FFFF)) begin
                perf_frz_d = perf_frz_q + 32'd1;
            end else begin
                perf_frz_d = perf_frz_q;
            end
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_haz_q <= 32'd0;
            perf_frz_q <= 32'd0;
        end else begin
            perf_haz_q <= perf_haz_d;
            perf_frz_q <= perf_frz_d;
        end
    end

    assign hc.perf_hazard_cycles = perf_haz_q;
    assign hc.perf_freeze_cycles = perf_frz_q;
`else
    logic perf_clr_unused_s;
    assign perf_clr_unused_s     = hc.perf_clr;
    assign hc.perf_hazard_cycles = 32'd0;
    assign hc.perf_freeze_cycles = 32'd0;
`endif

    assign hc.write_enable_IF_ID = we_if_id_s;
    assign hc.write_enable_ID_EX = we_id_ex_s;
    assign hc.write_enable_EX_M  = we_ex_m_s;
    assign hc.write_enable_M_WB  = we_m_wb_s;
    assign hc.stall_pc           = stall_pc_s;
    assign hc.bubble_ID_EX       = bubble_id_ex_s;
    assign hc.flush_IF_ID        = flush_if_id_s;
    assign hc.sb_busy            = busy_s;
    assign hc.stall_reason       = stall_reason_q;
endmodule
